// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the registered ALU.
package alu_pkg;

  localparam logic [3:0] OP_ORR  = 4'b0000;
  localparam logic [3:0] OP_ANDR = 4'b0001;
  localparam logic [3:0] OP_XORR = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_GT   = 4'b0110;
  localparam logic [3:0] OP_LT   = 4'b0111;
  localparam logic [3:0] OP_NOTR = 4'b1000;
  localparam logic [3:0] OP_EQ   = 4'b1001;
  localparam logic [3:0] OP_ADD  = 4'b1010;
  localparam logic [3:0] OP_SUB  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;
  localparam logic [3:0] OP_NOT  = 4'b1111;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one bit of b per cycle, LSB first, WIDTH cycles per product.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic                 busy_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_next;

  always_comb begin
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = busy_q && (cnt_q == CntW'(WIDTH - 1));
    // Final partial sum is presented combinationally so the caller can latch it on done.
    product  = acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered 16-op ALU with valid/ready on both sides; multiply is delegated to a
// sequential shift-add unit, everything else completes in one cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  state_e               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     x_q, y_q;
  logic                 zero_q;
  logic                 res_load;
  logic [2*WIDTH-1:0]   res_d;
  logic [2*WIDTH-1:0]   alu_res;
  logic [WIDTH:0]       sum, diff;
  logic                 accept;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_product;

  assign in_ready  = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath; carry/borrow fall out as bit WIDTH of the widened sum/difference.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    unique case (opcode)
      OP_ORR:  alu_res[0] = |a;
      OP_ANDR: alu_res[0] = &a;
      OP_XORR: alu_res[0] = ^a;
      OP_AND:  alu_res[WIDTH-1:0] = a & b;
      OP_OR:   alu_res[WIDTH-1:0] = a | b;
      OP_XOR:  alu_res[WIDTH-1:0] = a ^ b;
      OP_GT:   alu_res[0] = (a > b);
      OP_LT:   alu_res[0] = (a < b);
      OP_NOTR: alu_res[0] = (a == '0);
      OP_EQ:   alu_res[0] = (a == b);
      OP_ADD:  alu_res[WIDTH:0] = sum;
      OP_SUB:  alu_res[WIDTH:0] = diff;
      OP_MUL:  alu_res = '0;
      // Shift amounts >= 2*WIDTH naturally yield zero; no modulo wrap.
      OP_SHR:  alu_res = {{WIDTH{1'b0}}, a} >> b;
      OP_SHL:  alu_res = {{WIDTH{1'b0}}, a} << b;
      OP_NOT:  alu_res[WIDTH-1:0] = ~a;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_load    = 1'b0;
    res_d       = alu_res;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            state_d = S_MUL;
          end else begin
            out_valid_d = 1'b1;
            res_load    = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          res_load    = 1'b1;
          res_d       = mul_product;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      if (res_load) begin
        {y_q, x_q} <= res_d;
        zero_q     <= (res_d == '0);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign y         = y_q;
  assign zero      = zero_q;

endmodule
